// File: rtl/fb_pkg.sv
// Frame-buffer shared definitions.
// Geometry of the 80x60 RGB888 frame buffer and the arbiter state type.
// The display upscaler and the frame-buffer arbiter both use these
// constants.
package fb_pkg;

  localparam int unsigned          FB_ADDR_W    = 13;
  localparam int unsigned          FB_DATA_W    = 24;
  localparam int unsigned          FB_DEPTH     = 4800;
  localparam logic [FB_ADDR_W-1:0] FB_LAST_ADDR = 13'h12BF;

  // CLEAR: post-reset sweep, ARB: normal arbitration,
  // FORCE: single cycle in which the draw engine owns the RAM port.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    ARB   = 2'd1,
    FORCE = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_clear_seq.sv
// Clear-sweep address sequencer for the frame-buffer arbiter.
// Walks the word address from 0 to DEPTH-1, one step per enabled cycle.
// Only instantiated when FB_ARB_CLEAR_EN is defined.
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset (counter back to 0)
//   en_i    advance the counter this cycle
//   cnt_o   current sweep address
//   done_o  high while cnt_o addresses the last word
module fb_clear_seq
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W = FB_ADDR_W,
  parameter int unsigned DEPTH  = FB_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              done_o
);

  localparam int unsigned       LAST_I = DEPTH - 1;
  localparam logic [ADDR_W-1:0] LAST   = LAST_I[ADDR_W-1:0];

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = done_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter.
// Shares one DEPTH x DATA_W synchronous RAM between the display read path
// (priority) and the draw engine (writes). A draw request denied for
// MAX_WAIT consecutive cycles gets one forced slot. Optional post-reset
// clear sweep is enabled by defining FB_ARB_CLEAR_EN.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   disp_req/addr -> disp_gnt     display read request / same-cycle grant
//   disp_rvalid/rdata             read data, two cycles after the grant
//   drw_req/addr/data -> drw_ack  draw write request / same-cycle accept
//   drw_err                       accepted write was out of range, dropped
//   busy                          clear sweep in progress
//   mem_addr/we/wdata             registered RAM port
//   mem_rdata                     RAM read data (1-cycle latency)
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned       ADDR_W      = FB_ADDR_W,
  parameter int unsigned       DATA_W      = FB_DATA_W,
  parameter int unsigned       DEPTH       = FB_DEPTH,
  parameter int unsigned       MAX_WAIT    = 16,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              drw_req,
  input  logic [ADDR_W-1:0] drw_addr,
  input  logic [DATA_W-1:0] drw_data,
  output logic              drw_ack,
  output logic              drw_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned       WAIT_W     = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned       WAIT_TOP_I = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;
  localparam logic [WAIT_W-1:0] WAIT_TOP   = WAIT_TOP_I[WAIT_W-1:0];
  localparam logic [ADDR_W:0]   DEPTH_X    = DEPTH[ADDR_W:0];

  fb_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rd_pend_q;
  logic              rvalid_q;
  logic              gnt, ack, denied, in_range;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_done;

`ifdef FB_ARB_CLEAR_EN
  localparam fb_state_e RST_STATE = CLEAR;
  logic clr_en;

  assign clr_en = (state_q == CLEAR);
  assign busy   = clr_en;

  fb_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (clr_en),
    .cnt_o  (clr_addr),
    .done_o (clr_done)
  );
`else
  localparam fb_state_e RST_STATE = ARB;

  // CLEAR is unreachable in this build; ties let it fall straight to ARB.
  assign clr_addr = '0;
  assign clr_done = 1'b1;
  assign busy     = 1'b0;
`endif

  assign in_range = ({1'b0, drw_addr} < DEPTH_X);
  assign denied   = drw_req & ~ack;

  always_comb begin
    state_d = state_q;
    gnt     = 1'b0;
    ack     = 1'b0;
    case (state_q)
      CLEAR: begin
        if (clr_done) state_d = ARB;
      end
      FORCE: begin
        ack     = drw_req;
        state_d = ARB;
      end
      default: begin
        gnt = disp_req;
        ack = drw_req & ~disp_req;
        if (drw_req && disp_req && (wait_q == WAIT_TOP)) state_d = FORCE;
      end
    endcase
  end

  // Denial counter runs in every state, saturating at MAX_WAIT-1.
  always_comb begin
    wait_d = '0;
    if (denied) begin
      wait_d = (wait_q == WAIT_TOP) ? wait_q : wait_q + 1'b1;
    end
  end

  // An out-of-range draw is consumed but never reaches the RAM; an idle
  // cycle keeps the last address so the RAM input does not toggle.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_q == CLEAR) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = clr_addr;
      mem_wdata_d = CLEAR_COLOR;
    end else if (gnt) begin
      mem_addr_d = disp_addr;
    end else if (ack && in_range) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = drw_addr;
      mem_wdata_d = drw_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RST_STATE;
      wait_q      <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pend_q   <= gnt;
      rvalid_q    <= rd_pend_q;
    end
  end

  assign disp_gnt    = gnt;
  assign drw_ack     = ack;
  assign drw_err     = ack & ~in_range;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign disp_rvalid = rvalid_q;
  // The RAM output register is the data stage; gating by the registered
  // valid gives two-cycle latency and zero data while idle or in reset.
  assign disp_rdata  = rvalid_q ? mem_rdata : '0;

endmodule
